vga_timing_gen: RTL and testbench

Parametrised VGA timing and pixel-fetch generator that succeeds the fixed 640x480 controller.
- Single clock domain: the vertical counter advances on horizontal wrap, not on a sync edge.
- Sync polarities are configurable.
- A programmable fetch latency is absorbed internally, so RGB, sync and blank leave the block aligned.
- Sits between the framebuffer/SDRAM read port and the DAC pins.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_timing_gen.sv | 177 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA mode constants, display control bundle and sizing helpers
package vga_timing_pkg;

    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_H_ACT     = 640;
    localparam int VGA640_V_FRONT   = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BACK    = 33;
    localparam int VGA640_V_ACT     = 480;
    localparam int VGA640_PIXEL_KHZ = 25175;

    localparam int VGA800_H_FRONT   = 40;
    localparam int VGA800_H_SYNC    = 128;
    localparam int VGA800_H_BACK    = 88;
    localparam int VGA800_H_ACT     = 800;
    localparam int VGA800_V_FRONT   = 1;
    localparam int VGA800_V_SYNC    = 4;
    localparam int VGA800_V_BACK    = 23;
    localparam int VGA800_V_ACT     = 600;
    localparam int VGA800_PIXEL_KHZ = 40000;

    // Raw region flags travelling down the fetch-latency pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } disp_ctl_t;

    function automatic int axis_blank(input int front, input int sync, input int back);
        return front + sync + back;
    endfunction

    function automatic int axis_total(input int front, input int sync, input int back,
                                      input int act);
        return front + sync + back + act;
    endfunction

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: front/sync/back/active counter with region flags
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int FRONT = 16,
    parameter int SYNC  = 96,
    parameter int BACK  = 48,
    parameter int ACT   = 640,
    parameter int CNT_W = clog2_f(axis_total(FRONT, SYNC, BACK, ACT))
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iClr,
    input  logic             iAdv,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_act
);

    localparam int TOTAL = axis_total(FRONT, SYNC, BACK, ACT);
    localparam int BLANK = axis_blank(FRONT, SYNC, BACK);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(TOTAL - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_count <= '0;
        end else if (iClr) begin
            r_count <= '0;
        end else if (iAdv) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign count   = r_count;
    assign wrap    = w_last;
    assign in_sync = (r_count >= CNT_W'(FRONT)) && (r_count < CNT_W'(FRONT + SYNC));
    assign in_act  = (r_count >= CNT_W'(BLANK));

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing, pixel fetch and latency-aligned DAC outputs
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int H_ACT     = VGA640_H_ACT,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter int V_ACT     = VGA640_V_ACT,
    parameter int COLOR_W   = 4,
    parameter int FETCH_LAT = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int ADDR_W    = 22,
    parameter int COORD_W   = 11
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEnable,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [ADDR_W-1:0]  oAddress,
    output logic [COORD_W-1:0] oCurrent_X,
    output logic [COORD_W-1:0] oCurrent_Y,
    output logic               oFrameStart,
    output logic               oLineStart,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_CLOCK
);

    localparam int H_TOTAL = axis_total(H_FRONT, H_SYNC, H_BACK, H_ACT);
    localparam int V_TOTAL = axis_total(V_FRONT, V_SYNC, V_BACK, V_ACT);
    localparam int H_BLANK = axis_blank(H_FRONT, H_SYNC, H_BACK);
    localparam int V_BLANK = axis_blank(V_FRONT, V_SYNC, V_BACK);
    localparam int H_CW    = clog2_f(H_TOTAL);
    localparam int V_CW    = clog2_f(V_TOTAL);
    localparam int D       = FETCH_LAT + 1;

    if (64'(H_ACT) * 64'(V_ACT) > (64'd1 << ADDR_W)) begin : g_addr_chk
        $error("vga_timing_gen: H_ACT*V_ACT does not fit in ADDR_W bits");
    end
    if (ADDR_W > 32) begin : g_addr_w_chk
        $error("vga_timing_gen: ADDR_W above 32 is not supported");
    end
    if (FETCH_LAT < 0 || FETCH_LAT > 15) begin : g_lat_chk
        $error("vga_timing_gen: FETCH_LAT must be 0..15");
    end

    logic [H_CW-1:0]    w_h;
    logic [V_CW-1:0]    w_v;
    logic               w_h_wrap, w_v_wrap;
    logic               w_h_sync, w_v_sync;
    logic               w_h_act, w_v_act;
    logic               w_clr;
    logic               w_fetch_act;
    logic [COORD_W-1:0] w_x, w_y;
    disp_ctl_t          w_raw;

    assign w_clr = ~iEnable;

    vga_axis_counter #(
        .FRONT (H_FRONT),
        .SYNC  (H_SYNC),
        .BACK  (H_BACK),
        .ACT   (H_ACT),
        .CNT_W (H_CW)
    ) u_h_cnt (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iClr    (w_clr),
        .iAdv    (1'b1),
        .count   (w_h),
        .wrap    (w_h_wrap),
        .in_sync (w_h_sync),
        .in_act  (w_h_act)
    );

    // Lines advance on the last pixel of a line, never on a sync edge.
    vga_axis_counter #(
        .FRONT (V_FRONT),
        .SYNC  (V_SYNC),
        .BACK  (V_BACK),
        .ACT   (V_ACT),
        .CNT_W (V_CW)
    ) u_v_cnt (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iClr    (w_clr),
        .iAdv    (w_h_wrap),
        .count   (w_v),
        .wrap    (w_v_wrap),
        .in_sync (w_v_sync),
        .in_act  (w_v_act)
    );

    assign w_raw = '{hs: w_h_sync, vs: w_v_sync, act: w_h_act & w_v_act};

    // Tracks "counters sit at (0,0)" without a wide compare on both axes.
    logic r_origin;
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_origin <= 1'b1;
        end else if (w_clr) begin
            r_origin <= 1'b1;
        end else begin
            r_origin <= w_h_wrap & w_v_wrap;
        end
    end

    assign oFrameStart = r_origin & iEnable & iRST_N;
    assign oLineStart  = (w_h == H_CW'(H_BLANK)) & w_v_act;
    assign oRequest    = w_raw.act;

    assign w_x = w_raw.act ? COORD_W'(w_h - H_CW'(H_BLANK)) : '0;
    assign w_y = w_raw.act ? COORD_W'(w_v - V_CW'(V_BLANK)) : '0;

    assign oCurrent_X = w_x;
    assign oCurrent_Y = w_y;
    assign oAddress   = ADDR_W'(32'(w_y) * 32'(H_ACT) + 32'(w_x));

    disp_ctl_t r_pipe [D];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < D; i++) r_pipe[i] <= '0;
        end else if (w_clr) begin
            for (int i = 0; i < D; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i < D; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Colour is sampled when the requesting cycle's flag has aged FETCH_LAT stages.
    if (FETCH_LAT == 0) begin : g_lat0
        assign w_fetch_act = w_raw.act;
    end else begin : g_latn
        assign w_fetch_act = r_pipe[FETCH_LAT-1].act;
    end

    logic [COLOR_W-1:0] r_red, r_green, r_blue;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_clr || !w_fetch_act) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= iRed;
            r_green <= iGreen;
            r_blue  <= iBlue;
        end
    end

    assign oVGA_R     = r_red;
    assign oVGA_G     = r_green;
    assign oVGA_B     = r_blue;
    assign oVGA_HS    = r_pipe[D-1].hs ? HS_POL : ~HS_POL;
    assign oVGA_VS    = r_pipe[D-1].vs ? VS_POL : ~VS_POL;
    assign oVGA_BLANK = r_pipe[D-1].act;
    assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on two reduced timing sets
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // A: H 3/4/2/16 (total 25), V 2/2/1/6 (total 11), latency 2, active-low syncs.
    logic [3:0] red_a, green_a, blue_a, r_a, g_a, b_a;
    logic       req_a, fs_a, ls_a, hs_a, vs_a, blank_a, vclk_a;
    logic [7:0] addr_a;
    logic [5:0] x_a, y_a;
    logic [7:0] hist1, hist2;

    // B: H 2/3/1/4 (total 10), V 1/1/1/2 (total 5), latency 0, active-high syncs.
    logic [3:0] red_b, green_b, blue_b, r_b, g_b, b_b;
    logic       req_b, fs_b, ls_b, hs_b, vs_b, blank_b, vclk_b;
    logic [3:0] addr_b, x_b, y_b;

    always @(posedge clk) begin
        hist1 <= addr_a;
        hist2 <= hist1;
    end
    assign red_a   = hist2[3:0];
    assign green_a = hist2[7:4];
    assign blue_a  = 4'hA;
    assign red_b   = addr_b;
    assign green_b = ~addr_b;
    assign blue_b  = 4'h5;

    vga_timing_gen #(
        .H_FRONT(3), .H_SYNC(4), .H_BACK(2), .H_ACT(16),
        .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .V_ACT(6),
        .COLOR_W(4), .FETCH_LAT(2), .HS_POL(1'b0), .VS_POL(1'b0),
        .ADDR_W(8), .COORD_W(6)
    ) u_dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iEnable(enable),
        .iRed(red_a), .iGreen(green_a), .iBlue(blue_a),
        .oRequest(req_a), .oAddress(addr_a), .oCurrent_X(x_a), .oCurrent_Y(y_a),
        .oFrameStart(fs_a), .oLineStart(ls_a),
        .oVGA_R(r_a), .oVGA_G(g_a), .oVGA_B(b_a),
        .oVGA_HS(hs_a), .oVGA_VS(vs_a), .oVGA_BLANK(blank_a), .oVGA_CLOCK(vclk_a)
    );

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_ACT(4),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(2),
        .COLOR_W(4), .FETCH_LAT(0), .HS_POL(1'b1), .VS_POL(1'b1),
        .ADDR_W(4), .COORD_W(4)
    ) u_dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iEnable(enable),
        .iRed(red_b), .iGreen(green_b), .iBlue(blue_b),
        .oRequest(req_b), .oAddress(addr_b), .oCurrent_X(x_b), .oCurrent_Y(y_b),
        .oFrameStart(fs_b), .oLineStart(ls_b),
        .oVGA_R(r_b), .oVGA_G(g_b), .oVGA_B(b_b),
        .oVGA_HS(hs_b), .oVGA_VS(vs_b), .oVGA_BLANK(blank_b), .oVGA_CLOCK(vclk_b)
    );

    typedef struct packed {
        logic       req, fs, ls;
        logic [5:0] x, y;
        logic [7:0] addr;
        logic       hs, vs, blank;
        logic [3:0] r, g, b;
    } obs_a_t;

    typedef struct packed {
        logic       req, fs, ls;
        logic [3:0] x, y, addr;
        logic       hs, vs, blank;
        logic [3:0] r, g, b;
    } obs_b_t;

    obs_a_t obs_a;
    obs_b_t obs_b;
    assign obs_a = {req_a, fs_a, ls_a, x_a, y_a, addr_a, hs_a, vs_a, blank_a, r_a, g_a, b_a};
    assign obs_b = {req_b, fs_b, ls_b, x_b, y_b, addr_b, hs_b, vs_b, blank_b, r_b, g_b, b_b};

    // Reference for A, k = cycles since the first cycle after release/enable.
    function automatic obs_a_t exp_a(input int k);
        obs_a_t e;
        int h, v, j, hj, vj, a;
        h = k % 25;
        v = (k / 25) % 11;
        e = '0;
        e.req = (h >= 9) && (v >= 5);
        if (e.req) begin
            e.x    = 6'(h - 9);
            e.y    = 6'(v - 5);
            e.addr = 8'((v - 5) * 16 + h - 9);
        end
        e.fs = (h == 0) && (v == 0);
        e.ls = (h == 9) && (v >= 5);
        e.hs = 1'b1;
        e.vs = 1'b1;
        j = k - 3;
        if (j >= 0) begin
            hj = j % 25;
            vj = (j / 25) % 11;
            e.hs = !((hj >= 3) && (hj < 7));
            e.vs = !((vj >= 2) && (vj < 4));
            if ((hj >= 9) && (vj >= 5)) begin
                a       = (vj - 5) * 16 + hj - 9;
                e.blank = 1'b1;
                e.r     = 4'(a);
                e.g     = 4'(a >> 4);
                e.b     = 4'hA;
            end
        end
        return e;
    endfunction

    function automatic obs_b_t exp_b(input int k);
        obs_b_t e;
        int h, v, j, hj, vj, a;
        h = k % 10;
        v = (k / 10) % 5;
        e = '0;
        e.req = (h >= 6) && (v >= 3);
        if (e.req) begin
            e.x    = 4'(h - 6);
            e.y    = 4'(v - 3);
            e.addr = 4'((v - 3) * 4 + h - 6);
        end
        e.fs = (h == 0) && (v == 0);
        e.ls = (h == 6) && (v >= 3);
        j = k - 1;
        if (j >= 0) begin
            hj = j % 10;
            vj = (j / 10) % 5;
            e.hs = (hj >= 2) && (hj < 5);
            e.vs = (vj == 1);
            if ((hj >= 6) && (vj >= 3)) begin
                a       = (vj - 3) * 4 + hj - 6;
                e.blank = 1'b1;
                e.r     = 4'(a);
                e.g     = ~4'(a);
                e.b     = 4'h5;
            end
        end
        return e;
    endfunction

    task automatic reset_and_release();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({hs_a, vs_a, blank_a} !== 3'b110) begin
            n_errors++;
            $display("FAIL reset_sync_a got=%b exp=110", {hs_a, vs_a, blank_a});
        end
        n_checks++;
        if ({req_a, fs_a, ls_a} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_pulses_a got=%b exp=000", {req_a, fs_a, ls_a});
        end
        n_checks++;
        if ({r_a, g_a, b_a} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_rgb_a got=%h exp=000", {r_a, g_a, b_a});
        end
        n_checks++;
        if ({hs_b, vs_b, blank_b, req_b, fs_b} !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset_b got=%b exp=00000", {hs_b, vs_b, blank_b, req_b, fs_b});
        end
    endtask

    task automatic test_timing_a();
        obs_a_t e;
        int req_cnt = 0, hs_low = 0, vs_low = 0, fs_cnt = 0, first_hs = -1;
        logic [7:0] last_addr = '0;
        logic [5:0] last_x = '0, last_y = '0;
        reset_and_release();
        for (int k = 0; k <= 560; k++) begin
            @(negedge clk);
            e = exp_a(k);
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL cycle_a k=%0d got=%h exp=%h", k, obs_a, e);
            end
            if (fs_a) fs_cnt++;
            if (k < 275) begin
                if (req_a) begin
                    req_cnt++;
                    last_addr = addr_a;
                    last_x    = x_a;
                    last_y    = y_a;
                end
                if (!hs_a) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = k;
                end
                if (!vs_a) vs_low++;
            end
        end
        n_checks++;
        if (req_cnt != 96) begin
            n_errors++;
            $display("FAIL requests_per_frame_a got=%0d exp=96", req_cnt);
        end
        n_checks++;
        if ({last_addr, last_x, last_y} !== {8'd95, 6'd15, 6'd5}) begin
            n_errors++;
            $display("FAIL last_pixel_a got=%0d/%0d/%0d exp=95/15/5", last_addr, last_x, last_y);
        end
        n_checks++;
        if (first_hs != 6) begin
            n_errors++;
            $display("FAIL hs_first_fall_a got=%0d exp=6", first_hs);
        end
        n_checks++;
        if (hs_low != 44) begin
            n_errors++;
            $display("FAIL hs_low_cycles_a got=%0d exp=44", hs_low);
        end
        n_checks++;
        if (vs_low != 50) begin
            n_errors++;
            $display("FAIL vs_low_cycles_a got=%0d exp=50", vs_low);
        end
        n_checks++;
        if (fs_cnt != 3) begin
            n_errors++;
            $display("FAIL frame_starts_a got=%0d exp=3", fs_cnt);
        end
    endtask

    task automatic test_timing_b();
        obs_b_t e;
        int req_cnt = 0, hs_high = 0, vs_high = 0;
        reset_and_release();
        for (int k = 0; k <= 110; k++) begin
            @(negedge clk);
            e = exp_b(k);
            n_checks++;
            if (obs_b !== e) begin
                n_errors++;
                $display("FAIL cycle_b k=%0d got=%h exp=%h", k, obs_b, e);
            end
            if (k < 50) begin
                if (req_b) req_cnt++;
                if (hs_b) hs_high++;
                if (vs_b) vs_high++;
            end
        end
        n_checks++;
        if (req_cnt != 8) begin
            n_errors++;
            $display("FAIL requests_per_frame_b got=%0d exp=8", req_cnt);
        end
        n_checks++;
        if (hs_high != 15) begin
            n_errors++;
            $display("FAIL hs_high_cycles_b got=%0d exp=15", hs_high);
        end
        n_checks++;
        if (vs_high != 10) begin
            n_errors++;
            $display("FAIL vs_high_cycles_b got=%0d exp=10", vs_high);
        end
    endtask

    // Drop enable at H=15,V=6 (k=165), hold, then restart and replay a frame.
    task automatic test_enable_restart();
        obs_a_t e;
        obs_a_t hold;
        hold    = '0;
        hold.hs = 1'b1;
        hold.vs = 1'b1;
        reset_and_release();
        for (int k = 0; k <= 165; k++) begin
            @(negedge clk);
            e = exp_a(k);
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL pre_drop_a k=%0d got=%h exp=%h", k, obs_a, e);
            end
            if (k == 164) begin
                @(posedge clk);
                #1 enable = 1'b0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_a !== hold) begin
                n_errors++;
                $display("FAIL hold_a i=%0d got=%h exp=%h", i, obs_a, hold);
            end
            n_checks++;
            if ({hs_b, vs_b, blank_b, req_b, fs_b} !== 5'b00000) begin
                n_errors++;
                $display("FAIL hold_b i=%0d got=%b exp=00000", i, {hs_b, vs_b, blank_b, req_b, fs_b});
            end
        end
        @(posedge clk);
        #1 enable = 1'b1;
        for (int k = 0; k <= 280; k++) begin
            @(negedge clk);
            e = exp_a(k);
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL restart_a k=%0d got=%h exp=%h", k, obs_a, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing_a();
        test_timing_b();
        test_enable_restart();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
